// File: rtl/seq_tx_if.sv
// Handshake and serial-output bundle between a pattern requester and seq_tx.
// The master issues requests; the slave (seq_tx) drives the serial stream and status.
interface seq_tx_if #(
    parameter int W  = 6,
    parameter int RW = 3
);
    logic          start;
    logic          use_default;
    logic [W-1:0]  data;
    logic [RW-1:0] reps;
    logic          d;
    logic          valid;
    logic          busy;
    logic          done;
    logic [RW-1:0] sent;

    modport master (
        output start, use_default, data, reps,
        input  d, valid, busy, done, sent
    );

    modport slave (
        input  start, use_default, data, reps,
        output d, valid, busy, done, sent
    );
endinterface

// File: rtl/seq_tx.sv
// Serial pattern transmitter: latches a W-bit frame and shifts it out MSB-first,
// repeating it back-to-back, with a start/busy/done handshake and a wrapping frame count.
module seq_tx #(
    parameter int           W       = 6,
    parameter logic [W-1:0] PATTERN = 6'b101011,
    parameter int           RW      = 3
) (
    input logic     clk,
    input logic     rst,
    seq_tx_if.slave bus
);
    localparam int            IW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [W-1:0]  frame;
    logic [IW-1:0] idx;
    logic [RW-1:0] remaining;
    logic          d;
    logic          valid;
    logic          busy;
    logic          done;
    logic [RW-1:0] sent;

    // The accepting edge already drives the MSB, so IDLE+start selects the
    // incoming request as the source and otherwise the latched registers are used.
    logic          shifting;
    logic [W-1:0]  sel_frame;
    logic [IW-1:0] sel_idx;
    logic [RW-1:0] sel_rem;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        shifting  = (state == SHIFT);
        sel_frame = frame;
        sel_idx   = idx;
        sel_rem   = remaining;
        if (state == IDLE && bus.start) begin
            shifting  = 1'b1;
            sel_frame = bus.use_default ? PATTERN : bus.data;
            sel_idx   = LAST_IDX;
            sel_rem   = (bus.reps == '0) ? RW'(1) : bus.reps;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments only, so every read sees pre-edge values.
        if (rst) begin
            state     <= IDLE;
            frame     <= '0;
            idx       <= '0;
            remaining <= '0;
            d         <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sent      <= '0;
        end else if (shifting) begin
            frame <= sel_frame;
            d     <= sel_frame[sel_idx];
            valid <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
            if (sel_idx != '0) begin
                idx       <= sel_idx - IW'(1);
                remaining <= sel_rem;
                state     <= SHIFT;
            end else begin
                sent <= sent + RW'(1);
                if (sel_rem > RW'(1)) begin
                    // Reload for the next repeat with no gap cycle.
                    remaining <= sel_rem - RW'(1);
                    idx       <= LAST_IDX;
                    state     <= SHIFT;
                end else begin
                    remaining <= '0;
                    idx       <= '0;
                    state     <= DONE;
                end
            end
        end else if (state == DONE) begin
            d     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
        end else begin
            d     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
        end
    end

    assign bus.d     = d;
    assign bus.valid = valid;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.sent  = sent;
endmodule

// File: tb/tb_seq_tx.sv
// Randomized bench for seq_tx: a schedule-based model predicts every output cycle,
// plus directed requests whose serial streams are pinned against literal frames.
module tb_seq_tx;
    localparam int         W   = 6;
    localparam int         RW  = 3;
    localparam logic [5:0] PAT = 6'b101011;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_tx_if #(.W(W), .RW(RW)) bus ();

    seq_tx #(.W(W), .PATTERN(PAT), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request expands into its full per-cycle output schedule.
    typedef struct packed {
        logic          d;
        logic          valid;
        logic          busy;
        logic          done;
        logic [RW-1:0] sent;
    } obs_t;

    obs_t          sched[$];
    obs_t          exp_o;
    logic [RW-1:0] m_sent;

    function automatic obs_t mk(input logic dd, input logic v, input logic b, input logic dn,
                                input logic [RW-1:0] s);
        obs_t o;
        o.d = dd; o.valid = v; o.busy = b; o.done = dn; o.sent = s;
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            sched.delete();
            m_sent = '0;
            exp_o  = mk(1'b0, 1'b0, 1'b0, 1'b0, '0);
        end else begin
            if (sched.size() == 0 && bus.start) begin
                logic [W-1:0] fr;
                int           n;
                fr = bus.use_default ? PAT : bus.data;
                n  = (bus.reps == 0) ? 1 : int'(bus.reps);
                for (int f = 0; f < n; f++) begin
                    for (int b = W - 1; b >= 0; b--) begin
                        if (b == 0) m_sent = m_sent + 1'b1;
                        sched.push_back(mk(fr[b], 1'b1, 1'b1, 1'b0, m_sent));
                    end
                end
                sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, m_sent));
            end
            if (sched.size() > 0) exp_o = sched.pop_front();
            else                  exp_o = mk(1'b0, 1'b0, 1'b0, 1'b0, m_sent);
        end
    end

    always @(negedge clk) begin
        check("d",     {31'b0, bus.d},     {31'b0, exp_o.d});
        check("valid", {31'b0, bus.valid}, {31'b0, exp_o.valid});
        check("busy",  {31'b0, bus.busy},  {31'b0, exp_o.busy});
        check("done",  {31'b0, bus.done},  {31'b0, exp_o.done});
        check("sent",  {29'b0, bus.sent},  {29'b0, exp_o.sent});
    end

    // Issues one request from a negedge and collects the stream until done.
    task automatic run_req(input logic ud, input logic [5:0] dat, input logic [2:0] r,
                           input bit noisy, output logic [63:0] bits, output int nb,
                           output int cyc);
        bits = '0; nb = 0; cyc = 0;
        bus.start = 1'b1; bus.use_default = ud; bus.data = dat; bus.reps = r;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.valid) begin
                bits = {bits[62:0], bus.d};
                nb++;
            end
            if (bus.done) break;
            bus.start       = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.use_default = 1'($urandom);
            bus.data        = 6'($urandom);
            bus.reps        = 3'($urandom);
        end
        bus.start = 1'b0;
        check("req_done_seen", {31'b0, bus.done}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.valid && !bus.done) break;
        end
        check("idle_reached", {30'b0, bus.valid, bus.done}, 32'd0);
    endtask

    initial begin
        logic [63:0] bits;
        int          nb;
        int          cyc;
        logic [17:0] exp18;
        logic [11:0] exp12;
        logic [5:0]  dat;

        bus.start = 1'b0; bus.use_default = 1'b0; bus.data = '0; bus.reps = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, bus.valid}, 32'd0);
        check("rst_sent",  {29'b0, bus.sent},  32'd0);
        rst = 1'b0;

        // Built-in pattern, single frame.
        run_req(1'b1, 6'h00, 3'd1, 1'b0, bits, nb, cyc);
        check("def_bits",   bits[31:0], 32'b101011);
        check("def_nbits",  nb,  32'd6);
        check("def_span",   cyc, 32'd7);
        check("def_sent",   {29'b0, bus.sent}, 32'd1);
        @(negedge clk);
        check("def_busy_low", {30'b0, bus.busy, bus.done}, 32'd0);

        // User word, three repeats, with start/input noise during the transfer.
        exp18 = {3{6'b110010}};
        run_req(1'b0, 6'b110010, 3'd3, 1'b1, bits, nb, cyc);
        check("rep3_bits",  bits[31:0], {14'b0, exp18});
        check("rep3_nbits", nb,  32'd18);
        check("rep3_span",  cyc, 32'd19);
        check("rep3_sent",  {29'b0, bus.sent}, 32'd4);
        @(negedge clk);

        // Built-in pattern twice, as seen by a downstream detector.
        exp12 = {2{6'b101011}};
        run_req(1'b1, 6'h3f, 3'd2, 1'b0, bits, nb, cyc);
        check("rep2_bits", bits[31:0], {20'b0, exp12});
        check("rep2_sent", {29'b0, bus.sent}, 32'd6);
        @(negedge clk);

        // Reset after the third bit of a frame aborts cleanly.
        bus.start = 1'b1; bus.use_default = 1'b1; bus.reps = 3'd1;
        nb = 0;
        for (int i = 0; i < 20 && nb < 3; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.valid) nb++;
        end
        check("abort_bits_before", nb, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outs", {28'b0, bus.d, bus.valid, bus.busy, bus.done}, 32'd0);
        check("abort_sent", {29'b0, bus.sent}, 32'd0);
        rst = 1'b0;
        run_req(1'b1, 6'h00, 3'd1, 1'b0, bits, nb, cyc);
        check("after_abort_bits", bits[31:0], 32'b101011);
        check("after_abort_sent", {29'b0, bus.sent}, 32'd1);
        @(negedge clk);

        // reps=0 sends one frame.
        dat = 6'($urandom);
        run_req(1'b0, dat, 3'd0, 1'b0, bits, nb, cyc);
        check("reps0_nbits", nb, 32'd6);
        check("reps0_bits",  bits[31:0], {26'b0, dat});
        check("reps0_sent",  {29'b0, bus.sent}, 32'd2);
        @(negedge clk);

        // Seven more single frames: nine since reset, so sent wraps to 1.
        for (int k = 0; k < 7; k++) begin
            run_req(1'($urandom), 6'($urandom), 3'(k % 2), 1'b0, bits, nb, cyc);
            @(negedge clk);
        end
        check("wrap_sent", {29'b0, bus.sent}, 32'd1);

        // start held high: restart lands one cycle after done.
        bus.start = 1'b1; bus.use_default = 1'b0; bus.data = 6'($urandom); bus.reps = 3'd1;
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
        end
        check("held_done", {31'b0, bus.done}, 32'd1);
        check("held_span", cyc, 32'd7);
        @(negedge clk);
        check("held_restart_valid", {31'b0, bus.valid}, 32'd1);
        bus.start = 1'b0;
        wait_idle();

        // Random traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            bus.start       = ($urandom_range(0, 9) < 3);
            bus.use_default = 1'($urandom);
            bus.data        = 6'($urandom);
            bus.reps        = 3'($urandom);
            rst             = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
